// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write port arbiter: WB-stage writes vs. a 2-entry MDU result buffer
// Optional starvation protection (FORCE state, wait counter, PIPE_STALL) is built when WB_ARB_STARVE_EN is defined.
module reg_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_ADDR,
  input  logic [31:0] PIPE_DATA,
  input  logic        MDU_VALID,
  input  logic [4:0]  MDU_ADDR,
  input  logic [31:0] MDU_DATA,
  output logic        MDU_READY,
  output logic        RF_WE,
  output logic [4:0]  RF_ADDR,
  output logic [31:0] RF_DATA,
  output logic        PIPE_STALL,
  input  logic [4:0]  RS1_ADDR,
  input  logic [4:0]  RS2_ADDR,
  output logic        PEND_HIT1,
  output logic        PEND_HIT2
);

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
`else
  typedef enum logic {S_IDLE, S_WAIT} state_t;
`endif

  state_t      r_state;
  logic [1:0]  r_count;
  logic        r_head;
  logic [1:0]  r_v;
  logic [4:0]  r_a [2];
  logic [31:0] r_d [2];
  logic        r_rf_we;
  logic [4:0]  r_rf_addr;
  logic [31:0] r_rf_data;

  logic        w_pipe_req, w_pipe_win, w_pop, w_head_wr, w_push, w_tail;
  logic [1:0]  w_squash, w_pop_mask, w_push_mask, w_count_nxt;

`ifdef WB_ARB_STARVE_EN
  logic [CW-1:0] r_wait_cnt;
  logic          w_cnt_hit;
  assign PIPE_STALL = (r_state == S_FORCE);
  assign w_cnt_hit  = (r_wait_cnt + CW'(1)) == CW'(STARVE_LIMIT);
`else
  logic w_unused_limit;
  assign w_unused_limit = |STARVE_LIMIT;
  assign PIPE_STALL     = 1'b0;
`endif

  // A full buffer never refills in the cycle it pops: ready looks only at the registered count.
  assign MDU_READY   = RESET & (r_count < 2'd2);
  assign w_push      = MDU_VALID & MDU_READY & (MDU_ADDR != 5'd0);
  assign w_pipe_req  = PIPE_WE & (PIPE_ADDR != 5'd0);
  assign w_pipe_win  = w_pipe_req & ~PIPE_STALL;
  assign w_pop       = ~w_pipe_win & (r_count != 2'd0);
  assign w_head_wr   = w_pop & r_v[r_head];
  assign w_tail      = r_head ^ (r_count == 2'd1);
  assign w_squash[0] = w_pipe_win & r_v[0] & (r_a[0] == PIPE_ADDR);
  assign w_squash[1] = w_pipe_win & r_v[1] & (r_a[1] == PIPE_ADDR);
  assign w_pop_mask  = w_pop  ? (2'b01 << r_head) : 2'b00;
  assign w_push_mask = w_push ? (2'b01 << w_tail) : 2'b00;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  assign PEND_HIT1 = (RS1_ADDR != 5'd0) &
                     ((r_v[0] & (r_a[0] == RS1_ADDR)) | (r_v[1] & (r_a[1] == RS1_ADDR)) |
                      (w_push & (MDU_ADDR == RS1_ADDR)));
  assign PEND_HIT2 = (RS2_ADDR != 5'd0) &
                     ((r_v[0] & (r_a[0] == RS2_ADDR)) | (r_v[1] & (r_a[1] == RS2_ADDR)) |
                      (w_push & (MDU_ADDR == RS2_ADDR)));

  assign RF_WE   = r_rf_we;
  assign RF_ADDR = r_rf_addr;
  assign RF_DATA = r_rf_data;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_v       <= 2'b00;
      r_a[0]    <= '0;
      r_a[1]    <= '0;
      r_d[0]    <= '0;
      r_d[1]    <= '0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_count <= w_count_nxt;
      // Squashed entries stay queued but invalid; they drain later without a write.
      r_v     <= (r_v & ~(w_squash | w_pop_mask)) | w_push_mask;
      if (w_pop)
        r_head <= ~r_head;
      if (w_push) begin
        r_a[w_tail] <= MDU_ADDR;
        r_d[w_tail] <= MDU_DATA;
      end
      r_rf_we <= w_pipe_win | w_head_wr;
      if (w_pipe_win) begin
        r_rf_addr <= PIPE_ADDR;
        r_rf_data <= PIPE_DATA;
      end else if (w_head_wr) begin
        r_rf_addr <= r_a[r_head];
        r_rf_data <= r_d[r_head];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
`ifdef WB_ARB_STARVE_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_push) r_state <= S_WAIT;
        S_WAIT: begin
          if (w_count_nxt == 2'd0)
            r_state <= S_IDLE;
`ifdef WB_ARB_STARVE_EN
          else if (!w_pop && w_cnt_hit)
            r_state <= S_FORCE;
`endif
        end
`ifdef WB_ARB_STARVE_EN
        S_FORCE: r_state <= (w_count_nxt == 2'd0) ? S_IDLE : S_WAIT;
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef WB_ARB_STARVE_EN
      if (w_pop)
        r_wait_cnt <= '0;
      else if (r_state == S_WAIT && r_wait_cnt != CW'(STARVE_LIMIT))
        r_wait_cnt <= r_wait_cnt + CW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter with a queue-based reference model
// Expectations follow WB_ARB_STARVE_EN the same way the design does.
module tb_reg_wb_arbiter;
  localparam int LIMIT = 4;

  logic        CLK, RESET;
  logic        PIPE_WE, MDU_VALID;
  logic [4:0]  PIPE_ADDR, MDU_ADDR, RS1_ADDR, RS2_ADDR;
  logic [31:0] PIPE_DATA, MDU_DATA;
  logic        MDU_READY, RF_WE, PIPE_STALL, PEND_HIT1, PEND_HIT2;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_DATA;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  reg_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
    .MDU_VALID(MDU_VALID), .MDU_ADDR(MDU_ADDR), .MDU_DATA(MDU_DATA),
    .MDU_READY(MDU_READY),
    .RF_WE(RF_WE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
    .PIPE_STALL(PIPE_STALL),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .PEND_HIT1(PEND_HIT1), .PEND_HIT2(PEND_HIT2)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of buffered results, each still live or already overwritten.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  int          run = 0;
  bit          e_we = 0;
  logic [4:0]  e_a = 0;
  logic [31:0] e_d = 0;

  function automatic bit pend(input logic [4:0] rs, input bit push);
    if (rs == 0) return 0;
    if (push && MDU_ADDR == rs) return 1;
    foreach (mq[i]) if (mq[i].v && mq[i].a == rs) return 1;
    return 0;
  endfunction

  always @(negedge CLK) begin
    bit stall, ready, push, pwin, popped;
    int n;
    ent_t h;
    if (started) begin
      if (!RESET) begin
        chk("m_rst_we", RF_WE, 0);
        chk("m_rst_addr", RF_ADDR, 0);
        chk("m_rst_data", RF_DATA, 0);
        chk("m_rst_ready", MDU_READY, 0);
        chk("m_rst_stall", PIPE_STALL, 0);
        chk("m_rst_hit1", PEND_HIT1, 0);
        chk("m_rst_hit2", PEND_HIT2, 0);
        mq.delete();
        run = 0; e_we = 0; e_a = 0; e_d = 0;
      end else begin
        n = mq.size();
`ifdef WB_ARB_STARVE_EN
        stall = (n > 0) && (run >= LIMIT);
`else
        stall = 0;
`endif
        ready = (n < 2);
        push  = MDU_VALID && ready && (MDU_ADDR != 0);
        chk("m_ready", MDU_READY, ready);
        chk("m_stall", PIPE_STALL, stall);
        chk("m_hit1", PEND_HIT1, pend(RS1_ADDR, push));
        chk("m_hit2", PEND_HIT2, pend(RS2_ADDR, push));
        chk("m_rf_we", RF_WE, e_we);
        chk("m_rf_addr", RF_ADDR, e_a);
        chk("m_rf_data", RF_DATA, e_d);
        pwin = PIPE_WE && (PIPE_ADDR != 0) && !stall;
        popped = 0;
        e_we = 0;
        if (pwin) begin
          e_we = 1; e_a = PIPE_ADDR; e_d = PIPE_DATA;
          foreach (mq[i]) if (mq[i].a == PIPE_ADDR) mq[i].v = 0;
        end else if (n > 0) begin
          h = mq.pop_front();
          popped = 1;
          if (h.v) begin
            e_we = 1; e_a = h.a; e_d = h.d;
          end
        end
        if (popped) run = 0;
        else if (n > 0 && run < LIMIT) run++;
        if (push) begin
          h.a = MDU_ADDR; h.d = MDU_DATA; h.v = 1;
          mq.push_back(h);
        end
      end
    end
  end

  task automatic drive(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    PIPE_WE = pwe; PIPE_ADDR = pa; PIPE_DATA = pd;
    MDU_VALID = mv; MDU_ADDR = ma; MDU_DATA = md;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1;
    RS1_ADDR = 0; RS2_ADDR = 0;
    drive(0, 0, 0, 0, 0, 0);
    #2 RESET = 0;
    #1 started = 1;
    tick(); tick();
    RESET = 1;
    #1;
    chk("reset_rf_we", RF_WE, 0);
    chk("reset_stall", PIPE_STALL, 0);
    chk("reset_ready", MDU_READY, 1);
    tick();

    // Plain pipe write, then an address-0 request that must be ignored.
    drive(1, 5, 42, 0, 0, 0);
    tick();
    chk("pipe_we", RF_WE, 1);
    chk("pipe_addr", RF_ADDR, 5);
    chk("pipe_data", RF_DATA, 42);
    drive(1, 0, 123, 0, 0, 0);
    tick();
    chk("pipe_x0_we", RF_WE, 0);
    chk("pipe_x0_hold", RF_DATA, 42);

    // Collision: x2=100 from the MDU while the pipe streams x1.
    RS1_ADDR = 2;
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 200 + c, c == 0, 2, 100);
      #1;
      chk("coll_hit1", PEND_HIT1, 1);
`ifdef WB_ARB_STARVE_EN
      chk("coll_stall", PIPE_STALL, c == 5);
`else
      chk("coll_stall", PIPE_STALL, 0);
`endif
      tick();
`ifdef WB_ARB_STARVE_EN
      if (c == 5) begin
        chk("coll_force_addr", RF_ADDR, 2);
        chk("coll_force_data", RF_DATA, 100);
      end else begin
        chk("coll_pipe_addr", RF_ADDR, 1);
        chk("coll_pipe_data", RF_DATA, 200 + c);
      end
`else
      chk("coll_pipe_addr", RF_ADDR, 1);
      chk("coll_pipe_data", RF_DATA, 200 + c);
`endif
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
`ifdef WB_ARB_STARVE_EN
    chk("coll_hit1_done", PEND_HIT1, 0);
    tick();
    chk("coll_idle_we", RF_WE, 0);
`else
    chk("coll_hit1_wait", PEND_HIT1, 1);
    tick();
    chk("coll_idle_we", RF_WE, 1);
    chk("coll_idle_addr", RF_ADDR, 2);
    chk("coll_idle_data", RF_DATA, 100);
`endif
    RS1_ADDR = 0;

    // Full buffer: x3=7, x4=8 queue behind the pipe; x5=11 must wait for space.
    for (int c = 0; c < 7; c++) begin
      drive(c < 4, 1, 300 + c, c <= 5, (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd5,
            (c == 0) ? 32'd7 : (c == 1) ? 32'd8 : 32'd11);
      #1;
      if (c >= 2 && c <= 4) chk("full_ready_lo", MDU_READY, 0);
      if (c == 5) chk("full_ready_hi", MDU_READY, 1);
      tick();
      if (c == 4) begin chk("full_x3_addr", RF_ADDR, 3); chk("full_x3_data", RF_DATA, 7); end
      if (c == 5) begin chk("full_x4_addr", RF_ADDR, 4); chk("full_x4_data", RF_DATA, 8); end
      if (c == 6) begin chk("full_x5_addr", RF_ADDR, 5); chk("full_x5_data", RF_DATA, 11); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Squash: buffered x6=9 is overwritten by a pipe write of x6=55.
    RS2_ADDR = 6;
    drive(1, 1, 400, 1, 6, 9);
    #1;
    chk("sq_hit2_push", PEND_HIT2, 1);
    tick();
    drive(1, 6, 55, 0, 0, 0);
    #1;
    chk("sq_hit2_buf", PEND_HIT2, 1);
    tick();
    chk("sq_pipe_addr", RF_ADDR, 6);
    chk("sq_pipe_data", RF_DATA, 55);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("sq_hit2_clr", PEND_HIT2, 0);
    tick();
    chk("sq_drain_we", RF_WE, 0);
    chk("sq_drain_data", RF_DATA, 55);
    RS2_ADDR = 0;

    // Same-cycle MDU push to the winning pipe address survives.
    drive(1, 7, 1, 1, 7, 2);
    tick();
    chk("young_pipe_data", RF_DATA, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("young_mdu_we", RF_WE, 1);
    chk("young_mdu_addr", RF_ADDR, 7);
    chk("young_mdu_data", RF_DATA, 2);

    // MDU offer to x0 is accepted and dropped.
    drive(0, 0, 0, 1, 0, 5);
    #1;
    chk("x0_ready", MDU_READY, 1);
    chk("x0_hit1", PEND_HIT1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("x0_no_write", RF_WE, 0);

    // Reset with two buffered entries.
    drive(1, 1, 500, 1, 8, 3);
    tick();
    drive(1, 1, 501, 1, 9, 4);
    tick();
    drive(1, 1, 502, 0, 0, 0);
    #1;
    chk("mr_full", MDU_READY, 0);
    RESET = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mr_async_we", RF_WE, 0);
    chk("mr_async_ready", MDU_READY, 0);
    tick();
    RESET = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mr_post_ready", MDU_READY, 1);
      tick();
      chk("mr_post_we", RF_WE, 0);
    end
    drive(1, 10, 77, 0, 0, 0);
    tick();
    chk("mr_first_we", RF_WE, 1);
    chk("mr_first_addr", RF_ADDR, 10);
    chk("mr_first_data", RF_DATA, 77);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
